alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- Execution unit on the consuming end of the reservation-station issue bus (exe_*). Computes RV32I integer, jump and branch results for one issued instruction per cycle.
- Results are queued in a small result FIFO and broadcast on the ALU result bus (alu_valid/alu_rob_id/alu_data) that the RS and ROB snoop.
- Asserts alu_full so the RS withholds issue when the FIFO cannot absorb in-flight work.

Parameters:
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2).
- ROB_ID_W, 4, width of ROB tag.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- rdy  in  1  global enable; when low, all state holds.
- rollback  in  1  mispredict flush, synchronous.
- exe_valid  in  1  issue strobe from RS.
- exe_opcode  in  7  opcode.
- exe_func3  in  3  funct3.
- exe_func1  in  1  instr bit 30 (SUB/SRA select).
- exe_data1  in  32  rs1 value.
- exe_data2  in  32  rs2 value.
- exe_imm  in  32  sign-extended I/U immediate.
- exe_off  in  32  sign-extended B/J offset.
- exe_pc  in  32  instruction PC.
- exe_rob_target  in  ROB_ID_W  destination ROB tag.
- cdb_ready  in  1  bus grant; head pops when alu_valid&&cdb_ready.
- alu_full  out  1  RS must not issue.
- alu_valid  out  1  head result valid.
- alu_rob_id  out  ROB_ID_W  head tag.
- alu_data  out  32  rd value.
- alu_jump  out  1  control transfer taken.
- alu_target  out  32  next PC for JAL/JALR/BRANCH.

Behaviour:
- Compute is combinational from exe_*; the result is written to the FIFO at the clk edge where exe_valid&&rdy&&!rollback. Base latency is one cycle: exe_valid at cycle t gives alu_valid at t+1 if the FIFO was empty.
- Opcode results:
  - LUI 0110111: data=imm.
  - AUIPC 0010111: data=pc+imm.
  - JAL 1101111: data=pc+4, target=pc+off, jump=1.
  - JALR 1100111: data=pc+4, target=(data1+imm)&~1, jump=1.
  - BRANCH 1100011: func3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. jump=cond, target=cond?pc+off:pc+4, data=0.
  - OP-IMM 0010011: second operand is imm, shamt=imm[4:0], func1 selects SRAI. func1 is ignored for ADDI.
  - OP 0110011: second operand is data2, shamt=data2[4:0], func1 selects SUB/SRA.
  - Unknown opcode: data=0, jump=0, target=pc+4.
- Non-control ops: jump=0, target=pc+4. All arithmetic is mod 2^32. SLT/BLT are signed; SLTU/BLTU are unsigned.
- FIFO: count 0..FIFO_DEPTH, wrap-around read/write pointers. Head drives alu_*. alu_valid=(count!=0)&&rdy.
- Simultaneous push and pop is allowed at any count, including full; count is then unchanged.
- alu_full=(count>=FIFO_DEPTH-1) (registered count; covers the one issue in flight).
- Push while count==FIFO_DEPTH and no pop: entry dropped, count unchanged (protocol violation; bench asserts).
- rollback (with rdy): count, pointers and alu_valid cleared next edge; the exe_valid in that cycle is discarded.
- rdy low: no push, no pop, alu_valid=0, state frozen.
- Reset values: count=0, pointers=0, alu_valid=0, alu_full=0, alu_rob_id=0, alu_data=0, alu_jump=0, alu_target=0. Reset mid-operation discards all entries immediately.

Optional Feature:
- ALU_BYPASS_EN defined: when count==0, exe_valid, cdb_ready and rdy are all high and rollback is low, the computed result drives alu_* combinationally in the same cycle and is not written to the FIFO. Latency is 0.
- ALU_BYPASS_EN undefined: always via FIFO; outputs come only from the head register, latency 1.

Decomposition:
- const.v: opcode and func3 defines, DATA_WID, ROB_ID_WID, ALU_FIFO_DEPTH default.
- Sub-module alu_calc: purely combinational decode/compute (data, jump, target).
- alu_unit holds the FIFO, count, handshake, rollback and bypass logic.

Test Plan:
- ADD x: opcode 0110011, func3 000, func1 0, data1=5, data2=7, rob 3, cdb_ready=1 → next cycle alu_valid=1, alu_rob_id=3, alu_data=12, alu_jump=0.
- SRA/SRAI: data1=0x80000000, imm=4, func1=1, OP-IMM func3 101 → alu_data=0xF8000000. SUB 3-5 → 0xFFFFFFFE.
- BLT: data1=-1, data2=1, pc=0x100, off=0x20 → jump=1, target=0x120. BLTU with the same operands → jump=0, target=0x104.
- JALR: pc=0x40, data1=0x1001, imm=0 → data=0x44, target=0x1000, jump=1.
- Back-pressure: cdb_ready=0, issue 3 ops → alu_full=1 at count 3; raise cdb_ready → drained in order, one per cycle, with correct tags.
- rollback with 2 queued entries plus exe_valid the same cycle → next cycle alu_valid=0, count 0, alu_full=0. Async rst pulse mid-burst → outputs zero immediately.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared opcode/func3 encodings, widths and the compute result type for the ALU slice.
package alu_unit_pkg;

    localparam int DATA_W         = 32;
    localparam int ROB_ID_WID     = 4;
    localparam int ALU_FIFO_DEPTH = 4;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              jump;
        logic [DATA_W-1:0] target;
    } calc_res_t;

endpackage

// File: rtl/alu_unit_if.sv
// Issue bus (exe_*) into the ALU and result bus (alu_*) out of it.
interface alu_unit_if #(
    parameter int ROB_ID_W = 4
) ();
    logic                exe_valid;
    logic [6:0]          exe_opcode;
    logic [2:0]          exe_func3;
    logic                exe_func1;
    logic [31:0]         exe_data1;
    logic [31:0]         exe_data2;
    logic [31:0]         exe_imm;
    logic [31:0]         exe_off;
    logic [31:0]         exe_pc;
    logic [ROB_ID_W-1:0] exe_rob_target;
    logic                cdb_ready;

    logic                alu_full;
    logic                alu_valid;
    logic [ROB_ID_W-1:0] alu_rob_id;
    logic [31:0]         alu_data;
    logic                alu_jump;
    logic [31:0]         alu_target;

    modport master (
        output exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
               exe_imm, exe_off, exe_pc, exe_rob_target, cdb_ready,
        input  alu_full, alu_valid, alu_rob_id, alu_data, alu_jump, alu_target
    );

    modport slave (
        input  exe_valid, exe_opcode, exe_func3, exe_func1, exe_data1, exe_data2,
               exe_imm, exe_off, exe_pc, exe_rob_target, cdb_ready,
        output alu_full, alu_valid, alu_rob_id, alu_data, alu_jump, alu_target
    );
endinterface

// File: rtl/alu_unit_calc.sv
// Purely combinational RV32I decode/compute: rd value, jump flag and next PC.
module alu_calc
    import alu_unit_pkg::*;
(
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              func1,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] off,
    input  logic [DATA_W-1:0] pc,
    output calc_res_t         res
);

    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        shamt;
    logic              is_op;
    logic [DATA_W-1:0] alu_out;
    logic              br_cond;

    always_comb begin
        pc4   = pc + 32'd4;
        is_op = (opcode == OPC_OP);
        op_b  = is_op ? data2 : imm;
        shamt = op_b[4:0];
    end

    always_comb begin
        alu_out = '0;
        case (func3)
            F3_ADD:  alu_out = (is_op && func1) ? data1 - op_b : data1 + op_b;
            F3_SLL:  alu_out = data1 << shamt;
            F3_SLT:  alu_out = {31'd0, $signed(data1) < $signed(op_b)};
            F3_SLTU: alu_out = {31'd0, data1 < op_b};
            F3_XOR:  alu_out = data1 ^ op_b;
            F3_SR:   alu_out = func1 ? DATA_W'($signed(data1) >>> shamt) : data1 >> shamt;
            F3_OR:   alu_out = data1 | op_b;
            F3_AND:  alu_out = data1 & op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (func3)
            F3_BEQ:  br_cond = (data1 == data2);
            F3_BNE:  br_cond = (data1 != data2);
            F3_BLT:  br_cond = ($signed(data1) < $signed(data2));
            F3_BGE:  br_cond = !($signed(data1) < $signed(data2));
            F3_BLTU: br_cond = (data1 < data2);
            F3_BGEU: br_cond = !(data1 < data2);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        res.data   = '0;
        res.jump   = 1'b0;
        res.target = pc4;
        case (opcode_e'(opcode))
            OPC_LUI:    res.data = imm;
            OPC_AUIPC:  res.data = pc + imm;
            OPC_JAL: begin
                res.data   = pc4;
                res.jump   = 1'b1;
                res.target = pc + off;
            end
            OPC_JALR: begin
                res.data   = pc4;
                res.jump   = 1'b1;
                res.target = (data1 + imm) & ~32'd1;
            end
            OPC_BRANCH: begin
                res.jump   = br_cond;
                res.target = br_cond ? pc + off : pc4;
            end
            OPC_OP_IMM, OPC_OP: res.data = alu_out;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: compute, result FIFO and result-bus handshake.
// Optional same-cycle bypass when the FIFO is empty: define ALU_BYPASS_EN.
module alu_unit
    import alu_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = ALU_FIFO_DEPTH,
    parameter int ROB_ID_W   = ROB_ID_WID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       rollback,
    alu_unit_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    calc_res_t           calc_res;
    calc_res_t           q_res [FIFO_DEPTH];
    logic [ROB_ID_W-1:0] q_rob [FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                head_valid;
    logic                bypass;
    logic                push;
    logic                pop;

    alu_calc u_calc (
        .opcode (bus.exe_opcode),
        .func3  (bus.exe_func3),
        .func1  (bus.exe_func1),
        .data1  (bus.exe_data1),
        .data2  (bus.exe_data2),
        .imm    (bus.exe_imm),
        .off    (bus.exe_off),
        .pc     (bus.exe_pc),
        .res    (calc_res)
    );

    always_comb begin
        head_valid = (count != '0) && rdy;
`ifdef ALU_BYPASS_EN
        bypass = (count == '0) && bus.exe_valid && bus.cdb_ready && rdy && !rollback;
`else
        bypass = 1'b0;
`endif
        pop  = head_valid && bus.cdb_ready;
        // a push into a full FIFO only lands when the head leaves in the same edge
        push = bus.exe_valid && rdy && !rollback && !bypass
               && ((count != CNT_W'(FIFO_DEPTH)) || pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_res[i] <= '0;
                q_rob[i] <= '0;
            end
        end else if (rdy) begin
            if (rollback) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    q_res[wr_ptr] <= calc_res;
                    q_rob[wr_ptr] <= bus.exe_rob_target;
                    wr_ptr        <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_comb begin
        bus.alu_full   = (count >= CNT_W'(FIFO_DEPTH - 1));
        bus.alu_valid  = head_valid;
        bus.alu_rob_id = q_rob[rd_ptr];
        bus.alu_data   = q_res[rd_ptr].data;
        bus.alu_jump   = q_res[rd_ptr].jump;
        bus.alu_target = q_res[rd_ptr].target;
        if (bypass) begin
            bus.alu_valid  = 1'b1;
            bus.alu_rob_id = bus.exe_rob_target;
            bus.alu_data   = calc_res.data;
            bus.alu_jump   = calc_res.jump;
            bus.alu_target = calc_res.target;
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized traffic against a queue model.
module tb_alu_unit;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rollback;

    alu_unit_if #(.ROB_ID_W(4)) bus ();

    alu_unit #(.FIFO_DEPTH(D), .ROB_ID_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] data;
        logic        jump;
        logic [31:0] target;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_calc(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                                      input logic [31:0] a, input logic [31:0] d2,
                                      input logic [31:0] imm, input logic [31:0] off,
                                      input logic [31:0] pc, input logic [3:0] rob);
        exp_t r;
        logic [31:0] b;
        int sh;
        bit cond;
        r.rob = rob; r.data = 0; r.jump = 0; r.target = pc + 4;
        if (opc == 7'b0110111) r.data = imm;
        else if (opc == 7'b0010111) r.data = pc + imm;
        else if (opc == 7'b1101111) begin r.data = pc + 4; r.jump = 1; r.target = pc + off; end
        else if (opc == 7'b1100111) begin
            r.data = pc + 4; r.jump = 1; r.target = {a[31:1] + imm[31:1] + 31'(a[0] & imm[0]), 1'b0};
        end else if (opc == 7'b1100011) begin
            case (f3)
                0: cond = (a == d2);
                1: cond = (a != d2);
                4: cond = int'(a) < int'(d2);
                5: cond = int'(a) >= int'(d2);
                6: cond = a < d2;
                7: cond = a >= d2;
                default: cond = 0;
            endcase
            r.jump = cond;
            r.target = cond ? pc + off : pc + 4;
        end else if (opc == 7'b0010011 || opc == 7'b0110011) begin
            b = (opc == 7'b0110011) ? d2 : imm;
            sh = int'(b[4:0]);
            case (f3)
                0: r.data = (opc == 7'b0110011 && f1) ? a + ~b + 1 : a + b;
                1: r.data = a << sh;
                2: r.data = (int'(a) < int'(b)) ? 1 : 0;
                3: r.data = (a < b) ? 1 : 0;
                4: r.data = a ^ b;
                5: r.data = (f1 && a[31]) ? ~((~a) >> sh) : a >> sh;
                6: r.data = a | b;
                default: r.data = a & b;
            endcase
        end
        return r;
    endfunction

    task automatic check_outputs();
        bit v;
        v = (q.size() != 0) && rdy;
        chk("valid", 32'(bus.alu_valid), 32'(v));
        chk("full", 32'(bus.alu_full), 32'(q.size() >= D - 1));
        if (v) begin
            chk("rob", 32'(bus.alu_rob_id), 32'(q[0].rob));
            chk("data", bus.alu_data, q[0].data);
            chk("jump", 32'(bus.alu_jump), 32'(q[0].jump));
            chk("target", bus.alu_target, q[0].target);
        end
    endtask

    task automatic tick();
        bit pop, push, r, rb;
        exp_t e;
        r = rdy; rb = rollback;
        pop = (q.size() != 0) && rdy && bus.cdb_ready;
        push = bus.exe_valid && rdy && !rollback;
        e = ref_calc(bus.exe_opcode, bus.exe_func3, bus.exe_func1, bus.exe_data1, bus.exe_data2,
                     bus.exe_imm, bus.exe_off, bus.exe_pc, bus.exe_rob_target);
        @(posedge clk);
        if (r) begin
            if (rb) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push && (q.size() < D)) q.push_back(e);
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic f1,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic [31:0] off, input logic [31:0] pc, input logic [3:0] rob);
        bus.exe_valid = 1; bus.exe_opcode = opc; bus.exe_func3 = f3; bus.exe_func1 = f1;
        bus.exe_data1 = d1; bus.exe_data2 = d2; bus.exe_imm = imm; bus.exe_off = off;
        bus.exe_pc = pc; bus.exe_rob_target = rob;
    endtask

    task automatic rst_check(input string tag);
        chk({tag, "_valid"}, 32'(bus.alu_valid), 0);
        chk({tag, "_full"}, 32'(bus.alu_full), 0);
        chk({tag, "_rob"}, 32'(bus.alu_rob_id), 0);
        chk({tag, "_data"}, bus.alu_data, 0);
        chk({tag, "_jump"}, 32'(bus.alu_jump), 0);
        chk({tag, "_target"}, bus.alu_target, 0);
    endtask

    task automatic rand_op(input logic [3:0] rob);
        logic [6:0] opcs [8];
        logic [2:0] bf3 [6];
        logic [6:0] opc;
        logic [2:0] f3;
        logic [31:0] d1, d2;
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                 7'b1100011, 7'b0010011, 7'b0110011, 7'b0001011};
        bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        opc = opcs[$urandom_range(7)];
        f3 = (opc == 7'b1100011) ? bf3[$urandom_range(5)] : 3'($urandom);
        d1 = $urandom;
        d2 = ($urandom_range(3) == 0) ? d1 : $urandom;
        set_op(opc, f3, 1'($urandom), d1, d2, $urandom, $urandom, $urandom, rob);
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0; bus.cdb_ready = 1;
        set_op(7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 4'd0);
        bus.exe_valid = 0;
        #2;
        rst_check("reset");
        @(negedge clk);
        rst = 0;
        tick();

        set_op(7'b0110011, 3'd0, 1'b0, 5, 7, 0, 0, 32'h10, 4'd3);
        tick();
        chk("add_data", bus.alu_data, 12);
        chk("add_rob", 32'(bus.alu_rob_id), 3);
        chk("add_jump", 32'(bus.alu_jump), 0);
        set_op(7'b0010011, 3'd5, 1'b1, 32'h80000000, 0, 4, 0, 32'h14, 4'd4);
        tick();
        chk("srai_data", bus.alu_data, 32'hF8000000);
        set_op(7'b0110011, 3'd0, 1'b1, 3, 5, 0, 0, 32'h18, 4'd5);
        tick();
        chk("sub_data", bus.alu_data, 32'hFFFFFFFE);
        set_op(7'b1100011, 3'd4, 1'b0, 32'hFFFFFFFF, 1, 0, 32'h20, 32'h100, 4'd6);
        tick();
        chk("blt_jump", 32'(bus.alu_jump), 1);
        chk("blt_target", bus.alu_target, 32'h120);
        set_op(7'b1100011, 3'd6, 1'b0, 32'hFFFFFFFF, 1, 0, 32'h20, 32'h100, 4'd7);
        tick();
        chk("bltu_jump", 32'(bus.alu_jump), 0);
        chk("bltu_target", bus.alu_target, 32'h104);
        set_op(7'b1100111, 3'd0, 1'b0, 32'h1001, 0, 0, 0, 32'h40, 4'd8);
        tick();
        chk("jalr_data", bus.alu_data, 32'h44);
        chk("jalr_target", bus.alu_target, 32'h1000);
        chk("jalr_jump", 32'(bus.alu_jump), 1);
        bus.exe_valid = 0;
        tick();

        // back-pressure: three queued, then drained in order
        bus.cdb_ready = 0;
        for (int i = 0; i < 3; i++) begin
            set_op(7'b0010011, 3'd0, 1'b0, i, 0, 100, 0, 0, 4'(5 + i));
            tick();
        end
        bus.exe_valid = 0;
        chk("bp_full", 32'(bus.alu_full), 1);
        chk("bp_head", 32'(bus.alu_rob_id), 5);
        bus.cdb_ready = 1;
        tick();
        chk("drain_1", 32'(bus.alu_rob_id), 6);
        tick();
        chk("drain_2", 32'(bus.alu_rob_id), 7);
        tick();
        chk("drain_empty", 32'(bus.alu_valid), 0);

        // rollback with two queued and one issuing
        bus.cdb_ready = 0;
        for (int i = 0; i < 2; i++) begin
            rand_op(4'(9 + i));
            tick();
        end
        rand_op(4'd11);
        rollback = 1;
        tick();
        rollback = 0;
        bus.exe_valid = 0;
        chk("rb_valid", 32'(bus.alu_valid), 0);
        chk("rb_full", 32'(bus.alu_full), 0);

        // rdy low freezes state and blocks issue
        rand_op(4'd12);
        tick();
        rdy = 0;
        rand_op(4'd13);
        tick();
        rdy = 1;
        bus.exe_valid = 0;
        tick();
        chk("rdy_hold", 32'(bus.alu_rob_id), 12);
        bus.cdb_ready = 1;
        tick();

        for (int n = 0; n < 400; n++) begin
            rdy = ($urandom_range(7) != 0);
            rollback = ($urandom_range(15) == 0);
            bus.cdb_ready = 1'($urandom);
            if (q.size() < D - 1 && $urandom_range(3) != 0) rand_op(4'($urandom));
            else bus.exe_valid = 0;
            tick();
        end
        rdy = 1; rollback = 0;

        // async reset mid-burst
        bus.cdb_ready = 0;
        for (int i = 0; i < 2; i++) begin
            rand_op(4'(1 + i));
            tick();
        end
        bus.exe_valid = 0;
        #2 rst = 1;
        #1 rst_check("midrst");
        q.delete();
        #1 rst = 0;
        bus.cdb_ready = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
